gpio_in_cond: RTL and testbench
===============================

Name: gpio_in_cond

Overview:
Input-conditioning stage that sits directly upstream of the SoC `gpio_in` port. It takes raw asynchronous pad inputs and produces clean per-bit values for the core:
- multi-flop synchroniser per bit;
- per-bit debounce counter;
- sticky rise/fall edge flags with a level interrupt.

It is instantiated beside SoC in the top level and in tb_soc-style benches.

Parameters:
- DW, 16: number of GPIO bits; matches the SoC data width.
- SYNC_STAGES, 2: synchroniser depth, range 2..4.
- DB_LIMIT, 4: consecutive mismatching cycles needed to accept a new level, range 1..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-low (0 = reset).
- pin_in  in  DW  raw asynchronous pad inputs.
- gpio_in  out  DW  debounced level; connects to SoC `gpio_in`.
- rise  out  DW  sticky rising-edge flags.
- fall  out  DW  sticky falling-edge flags.
- clr_en  in  1  clear strobe for the edge flags.
- clr_mask  in  DW  bits whose rise and fall flags are cleared when clr_en=1.
- irq  out  1  level interrupt, OR of the flags.

Behaviour:
- Reset (rst=0 at a clock edge): sync chain, stable level, counters, rise and fall all go to 0. Therefore gpio_in=0 and irq=0 on the next cycle. Reset overrides everything, including mid-count state; counting restarts from 0 after release.
- Synchroniser: at each edge, sync[0] ← pin_in and sync[k] ← sync[k-1]. The sampled value is s = sync[SYNC_STAGES-1]. No logic operates on pin_in before sync[0].
- Per-bit debounce, evaluated every edge, with counter cnt of width $clog2(DB_LIMIT+1):
  - If s == stable: cnt ← 0.
  - Else if cnt == DB_LIMIT-1: stable ← s and cnt ← 0.
  - Else: cnt ← cnt+1.
- Latency: if pin_in changes and is first sampled at edge 1, gpio_in changes after edge SYNC_STAGES+DB_LIMIT. With the defaults this is edge 6.
- Glitch rejection: any pulse shorter than DB_LIMIT cycles on s produces no change on gpio_in, and the counter returns to 0.
- gpio_in is the registered `stable` vector, with no combinational path from pin_in.
- Edge flags are set at the same edge that stable flips:
  - rise[i] is set on a 0→1 flip of bit i.
  - fall[i] is set on a 1→0 flip of bit i.
  - Flags hold until cleared.
- Clearing: when clr_en=1, at that edge rise[i] and fall[i] are cleared for every i with clr_mask[i]=1.
- Simultaneous set and clear on the same bit and flag: set wins, so the flag ends up 1.
- clr_en=0 ignores clr_mask.
- irq = |(rise | fall), computed combinationally from flag registers only.
- Power-up consequence: a pin held high through reset yields gpio_in=1 and rise=1 at edge SYNC_STAGES+DB_LIMIT after reset release. This is intended; firmware clears it at boot.
- Counter width never overflows because cnt ≤ DB_LIMIT-1. DB_LIMIT=1 means a single mismatching sample is accepted.

Optional Feature:
Macro `GPIO_IRQ_MASK_EN`.
- Defined: adds input port irq_mask (DW bits), and irq = |((rise | fall) & irq_mask). Flags still set and clear regardless of the mask.
- Undefined: the port is absent and all bits contribute to irq.

Decomposition:
- Package gpio_cond_pkg holds:
  - localparam DW_DEF=16, SYNC_DEF=2, DB_LIMIT_DEF=4;
  - function cnt_w(limit), returning $clog2(limit+1).
- Sub-module gpio_db_bit: one bit's synchroniser, counter, stable register and rise/fall pulse outputs. It is instantiated DW times in a generate loop.
- Flag registers and irq stay in gpio_in_cond.

Test Plan:
1. Bit 0: pin_in 0→1, first sampled at edge 1 and held. Expect gpio_in[0]=0 through edge 5, gpio_in[0]=1 after edge 6, rise[0]=1, irq=1.
2. Bit 3 glitch: pin_in high for 3 cycles, then low. Expect gpio_in=0, rise=0 and irq=0 throughout.
3. Bus pattern: pin_in=16'hFA1C held after reset release. Expect gpio_in=16'hFA1C, rise=16'hFA1C and fall=0 after edge 6.
4. Clearing from scenario 3: clr_en=1 with clr_mask=16'h000C for one cycle. Expect rise=16'hFA10 and irq still 1. Then clr_mask=16'hFFFF; expect rise=0 and irq=0.
5. Collision: clr_en=1 with clr_mask[5]=1 at the same edge bit 5 flips 0→1. Expect rise[5]=1 afterwards.
6. Reset mid-count: pin_in[2] goes high and rst=0 is applied at edge 4. Expect all outputs 0 after that edge. After release at edge 6 with the pin still high, expect gpio_in[2]=1 exactly SYNC_STAGES+DB_LIMIT edges later.

Source files
------------

// File: rtl/gpio_cond_pkg.sv
// Shared defaults and sizing helper for the GPIO input conditioner.
package gpio_cond_pkg;

    localparam int DW_DEF       = 16;
    localparam int SYNC_DEF     = 2;
    localparam int DB_LIMIT_DEF = 4;

    function automatic int cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/gpio_db_bit.sv
// One GPIO bit: synchroniser, debounce counter, stable level and flip pulses.
module gpio_db_bit
    import gpio_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_DEF,
    parameter int DB_LIMIT    = DB_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = cnt_w(DB_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_LIMIT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;
    logic [CW-1:0]          r_cnt;
    logic                   w_s;
    logic                   w_flip;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_flip = (w_s != r_stable) && (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            if (w_s == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= w_s;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = w_flip & w_s;
    assign o_fall  = w_flip & ~w_s;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: per-bit debounce plus sticky edge flags and irq.
// Optional GPIO_IRQ_MASK_EN adds an irq_mask input gating flag bits into irq.
module gpio_in_cond
    import gpio_cond_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int SYNC_STAGES = SYNC_DEF,
    parameter int DB_LIMIT    = DB_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pin_in,
    output logic [DW-1:0] gpio_in,
    output logic [DW-1:0] rise,
    output logic [DW-1:0] fall,
    input  logic          clr_en,
    input  logic [DW-1:0] clr_mask,
`ifdef GPIO_IRQ_MASK_EN
    input  logic [DW-1:0] irq_mask,
`endif
    output logic          irq
);

    logic [DW-1:0] w_level;
    logic [DW-1:0] w_rise_p;
    logic [DW-1:0] w_fall_p;
    logic [DW-1:0] w_clr;
    logic [DW-1:0] r_rise;
    logic [DW-1:0] r_fall;

    for (genvar g = 0; g < DW; g++) begin : g_bit
        gpio_db_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_LIMIT    (DB_LIMIT)
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .i_pin   (pin_in[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise_p[g]),
            .o_fall  (w_fall_p[g])
        );
    end

    assign w_clr = clr_en ? clr_mask : '0;

    // New edges are OR-ed in after the clear so a same-edge set survives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= (r_rise & ~w_clr) | w_rise_p;
            r_fall <= (r_fall & ~w_clr) | w_fall_p;
        end
    end

    assign gpio_in = w_level;
    assign rise    = r_rise;
    assign fall    = r_fall;

`ifdef GPIO_IRQ_MASK_EN
    assign irq = |((r_rise | r_fall) & irq_mask);
`else
    assign irq = |(r_rise | r_fall);
`endif

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed self-checking bench for gpio_in_cond with default parameters.
module tb_gpio_in_cond;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pin_in;
    logic [15:0] gpio_in;
    logic [15:0] rise;
    logic [15:0] fall;
    logic        clr_en;
    logic [15:0] clr_mask;
`ifdef GPIO_IRQ_MASK_EN
    logic [15:0] irq_mask = 16'hFFFF;
`endif
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_in_cond dut (
        .clk      (clk),
        .rst      (rst),
        .pin_in   (pin_in),
        .gpio_in  (gpio_in),
        .rise     (rise),
        .fall     (fall),
        .clr_en   (clr_en),
        .clr_mask (clr_mask),
`ifdef GPIO_IRQ_MASK_EN
        .irq_mask (irq_mask),
`endif
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        pin_in   = '0;
        clr_en   = 1'b0;
        clr_mask = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        pin_in = 16'hFFFF;
        clr_en = 1'b0;
        step();
        step();
        n_tests++;
        if (gpio_in !== 16'h0 || rise !== 16'h0 ||
            fall !== 16'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: gpio=%h rise=%h fall=%h irq=%b, want 0",
                     gpio_in, rise, fall, irq);
        end
    endtask

    task automatic test_latency();
        logic [15:0] exp;
        do_reset();
        pin_in = 16'h0001;
        for (int e = 1; e <= 6; e++) begin
            step();
            exp = (e >= 6) ? 16'h0001 : 16'h0000;
            n_tests++;
            if (gpio_in !== exp) begin
                n_fail++;
                $display("FAIL latency edge %0d: gpio=%h want %h",
                         e, gpio_in, exp);
            end
        end
        n_tests++;
        if (rise !== 16'h0001 || fall !== 16'h0 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL latency flags: rise=%h fall=%h irq=%b want 0001 0000 1",
                     rise, fall, irq);
        end
    endtask

    task automatic test_glitch();
        int bad;
        do_reset();
        pin_in = 16'h0008;
        step();
        step();
        step();
        pin_in = 16'h0000;
        bad = 0;
        for (int e = 0; e < 10; e++) begin
            step();
            if (gpio_in !== 16'h0 || rise !== 16'h0 || irq !== 1'b0)
                bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL glitch: %0d bad cycles, gpio=%h rise=%h irq=%b want 0",
                     bad, gpio_in, rise, irq);
        end
    endtask

    task automatic test_bus_and_clear();
        do_reset();
        pin_in = 16'hFA1C;
        for (int e = 1; e <= 5; e++) step();
        n_tests++;
        if (gpio_in !== 16'h0) begin
            n_fail++;
            $display("FAIL bus edge5: gpio=%h want 0000", gpio_in);
        end
        step();
        n_tests++;
        if (gpio_in !== 16'hFA1C || rise !== 16'hFA1C || fall !== 16'h0) begin
            n_fail++;
            $display("FAIL bus edge6: gpio=%h rise=%h fall=%h want FA1C FA1C 0000",
                     gpio_in, rise, fall);
        end
        clr_en   = 1'b0;
        clr_mask = 16'hFFFF;
        step();
        n_tests++;
        if (rise !== 16'hFA1C) begin
            n_fail++;
            $display("FAIL clr_en_low: rise=%h want FA1C", rise);
        end
        clr_en   = 1'b1;
        clr_mask = 16'h000C;
        step();
        clr_en = 1'b0;
        n_tests++;
        if (rise !== 16'hFA10 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_partial: rise=%h irq=%b want FA10 1", rise, irq);
        end
        clr_en   = 1'b1;
        clr_mask = 16'hFFFF;
        step();
        clr_en = 1'b0;
        n_tests++;
        if (rise !== 16'h0 || irq !== 1'b0 || gpio_in !== 16'hFA1C) begin
            n_fail++;
            $display("FAIL clr_all: rise=%h irq=%b gpio=%h want 0000 0 FA1C",
                     rise, irq, gpio_in);
        end
    endtask

    task automatic test_collision();
        do_reset();
        pin_in = 16'h0020;
        for (int e = 1; e <= 5; e++) step();
        clr_en   = 1'b1;
        clr_mask = 16'h0020;
        step();
        clr_en = 1'b0;
        n_tests++;
        if (rise !== 16'h0020 || gpio_in !== 16'h0020) begin
            n_fail++;
            $display("FAIL collision: rise=%h gpio=%h want 0020 0020",
                     rise, gpio_in);
        end
        pin_in = 16'h0000;
        for (int e = 1; e <= 6; e++) step();
        n_tests++;
        if (fall !== 16'h0020 || rise !== 16'h0020 || gpio_in !== 16'h0) begin
            n_fail++;
            $display("FAIL fall: fall=%h rise=%h gpio=%h want 0020 0020 0000",
                     fall, rise, gpio_in);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [15:0] exp;
        do_reset();
        pin_in = 16'h0004;
        step();
        step();
        step();
        rst = 1'b0;
        step();
        n_tests++;
        if (gpio_in !== 16'h0 || rise !== 16'h0 ||
            fall !== 16'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: gpio=%h rise=%h fall=%h irq=%b want 0",
                     gpio_in, rise, fall, irq);
        end
        step();
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k >= 5) begin
                exp = (k == 6) ? 16'h0004 : 16'h0000;
                n_tests++;
                if (gpio_in !== exp) begin
                    n_fail++;
                    $display("FAIL postreset edge %0d: gpio=%h want %h",
                             k, gpio_in, exp);
                end
            end
        end
        n_tests++;
        if (rise !== 16'h0004) begin
            n_fail++;
            $display("FAIL postreset rise: rise=%h want 0004", rise);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_bus_and_clear();
        test_collision();
        test_reset_mid_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
